// File: rtl/bist_signature_analyzer_pkg.sv
// rtl/bist_signature_analyzer_pkg.sv - shared BIST state encoding and chain/polynomial defaults
package bist_signature_analyzer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5
    } bist_state_t;

    // Shared with the pattern LFSR and the scan chain so all three agree.
    localparam int         DEF_CHAIN_LEN = 8;
    localparam logic [7:0] DEF_TAP_MASK  = 8'h8E;

endpackage

// File: rtl/sisr_register.sv
// rtl/sisr_register.sv - serial-input signature register with seed load
module sisr_register #(
    parameter int               SIG_W    = 8,
    parameter logic [SIG_W-1:0] TAP_MASK = SIG_W'(8'h8E),
    parameter logic [SIG_W-1:0] SEED     = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load_seed,
    input  logic             i_din,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;
    logic             w_fb;

    assign w_fb  = (^(r_sig & TAP_MASK)) ^ i_din;
    assign o_sig = r_sig;

    // Reseed takes priority over absorbing a bit; otherwise shift in feedback on enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sig <= SEED;
        end else if (i_load_seed) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= {r_sig[SIG_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/bist_signature_analyzer.sv
// rtl/bist_signature_analyzer.sv - scan_en sequencing and SISR compaction for the BIST response path
module bist_signature_analyzer
    import bist_signature_analyzer_pkg::*;
#(
    parameter int               CHAIN_LEN    = DEF_CHAIN_LEN,
    parameter int               NUM_PATTERNS = 16,
    parameter int               SIG_W        = 8,
    parameter logic [SIG_W-1:0] TAP_MASK     = SIG_W'(DEF_TAP_MASK),
    parameter logic [SIG_W-1:0] SEED         = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_scan_out,
    input  logic [SIG_W-1:0] i_golden_sig,
    output logic             o_scan_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [SIG_W-1:0] o_signature,
    output logic [7:0]       o_pattern_cnt
);

    localparam int              CNT_W      = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [7:0]      NUM_PAT    = 8'(NUM_PATTERNS);

    bist_state_t      r_state;
    bist_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_shift_cnt;
    logic [CNT_W-1:0] w_shift_cnt_nxt;
    logic [7:0]       r_pattern_cnt;
    logic [7:0]       w_pattern_cnt_nxt;
    logic [7:0]       w_pattern_inc;
    logic             r_scan_en;
    logic             w_scan_en_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_pass;
    logic             w_pass_nxt;
    logic             w_load_seed;
    logic             w_absorb;
    logic [SIG_W-1:0] w_signature;

    // Saturating capture count so a stray extra capture can never overflow past NUM_PATTERNS.
    assign w_pattern_inc = (r_pattern_cnt < NUM_PAT) ? (r_pattern_cnt + 8'd1) : r_pattern_cnt;

    // Next-state and next-output decode; start only acts from IDLE/DONE and beats a same-cycle step.
    always_comb begin
        w_state_nxt       = r_state;
        w_shift_cnt_nxt   = r_shift_cnt;
        w_pattern_cnt_nxt = r_pattern_cnt;
        w_scan_en_nxt     = r_scan_en;
        w_done_nxt        = r_done;
        w_pass_nxt        = r_pass;
        w_load_seed       = 1'b0;
        w_absorb          = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt       = ST_SHIFT;
                    w_shift_cnt_nxt   = '0;
                    w_pattern_cnt_nxt = 8'd0;
                    w_scan_en_nxt     = 1'b1;
                    w_done_nxt        = 1'b0;
                    w_pass_nxt        = 1'b0;
                    w_load_seed       = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (i_step) begin
                    w_absorb = 1'b1;
                    if (r_shift_cnt == SHIFT_LAST) begin
                        w_shift_cnt_nxt = '0;
                        w_state_nxt     = ST_CAPTURE;
                        w_scan_en_nxt   = 1'b0;
                    end else begin
                        w_shift_cnt_nxt = r_shift_cnt + 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (i_step) begin
                    w_pattern_cnt_nxt = w_pattern_inc;
                    w_scan_en_nxt     = 1'b1;
                    w_state_nxt       = (w_pattern_inc < NUM_PAT) ? ST_SHIFT : ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (i_step) begin
                    w_absorb = 1'b1;
                    if (r_shift_cnt == SHIFT_LAST) begin
                        w_shift_cnt_nxt = '0;
                        w_state_nxt     = ST_CHECK;
                        w_scan_en_nxt   = 1'b0;
                    end else begin
                        w_shift_cnt_nxt = r_shift_cnt + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
                w_pass_nxt  = (w_signature == i_golden_sig);
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_shift_cnt   <= '0;
            r_pattern_cnt <= 8'd0;
            r_scan_en     <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift_cnt   <= w_shift_cnt_nxt;
            r_pattern_cnt <= w_pattern_cnt_nxt;
            r_scan_en     <= w_scan_en_nxt;
            r_done        <= w_done_nxt;
            r_pass        <= w_pass_nxt;
        end
    end

    sisr_register #(
        .SIG_W    (SIG_W),
        .TAP_MASK (TAP_MASK),
        .SEED     (SEED)
    ) u_sisr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (w_absorb),
        .i_load_seed (w_load_seed),
        .i_din       (i_scan_out),
        .o_sig       (w_signature)
    );

    assign o_scan_en     = r_scan_en;
    assign o_busy        = (r_state == ST_SHIFT) || (r_state == ST_CAPTURE) ||
                           (r_state == ST_UNLOAD) || (r_state == ST_CHECK);
    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_signature   = w_signature;
    assign o_pattern_cnt = r_pattern_cnt;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// tb/tb_bist_signature_analyzer.sv - self-checking bench for bist_signature_analyzer
module tb_bist_signature_analyzer;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_start, a_step, a_scan_out;
    logic [7:0] a_golden;
    logic       a_scan_en, a_busy, a_done, a_pass;
    logic [7:0] a_sig, a_pcnt;

    logic       b_start, b_step, b_scan_out;
    logic [7:0] b_golden;
    logic       b_scan_en, b_busy, b_done, b_pass;
    logic [7:0] b_sig, b_pcnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] q_sig[$];
    logic       q_en[$];

    always #5 clk = ~clk;

    bist_signature_analyzer #(
        .CHAIN_LEN    (2),
        .NUM_PATTERNS (1)
    ) dut_a (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (a_start),
        .i_step        (a_step),
        .i_scan_out    (a_scan_out),
        .i_golden_sig  (a_golden),
        .o_scan_en     (a_scan_en),
        .o_busy        (a_busy),
        .o_done        (a_done),
        .o_pass        (a_pass),
        .o_signature   (a_sig),
        .o_pattern_cnt (a_pcnt)
    );

    bist_signature_analyzer dut_b (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (b_start),
        .i_step        (b_step),
        .i_scan_out    (b_scan_out),
        .i_golden_sig  (b_golden),
        .o_scan_en     (b_scan_en),
        .o_busy        (b_busy),
        .o_done        (b_done),
        .o_pass        (b_pass),
        .o_signature   (b_sig),
        .o_pattern_cnt (b_pcnt)
    );

    function automatic logic [7:0] sisr_model(input logic [7:0] s, input logic b);
        logic [7:0] taps;
        taps = s & 8'h8E;
        return {s[6:0], (taps[7] ^ taps[3] ^ taps[2] ^ taps[1]) ^ b};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({a_scan_en, a_busy, a_done, a_pass} !== 4'b0000) begin
            bad++; $display("FAIL reset_a_flags got=%b want=0000", {a_scan_en, a_busy, a_done, a_pass});
        end
        total++;
        if (a_sig !== 8'h00 || a_pcnt !== 8'h00) begin
            bad++; $display("FAIL reset_a_sig_cnt got=%h/%h want=00/00", a_sig, a_pcnt);
        end
        total++;
        if ({b_scan_en, b_busy, b_done, b_pass} !== 4'b0000) begin
            bad++; $display("FAIL reset_b_flags got=%b want=0000", {b_scan_en, b_busy, b_done, b_pass});
        end
        total++;
        if (b_sig !== 8'h00 || b_pcnt !== 8'h00) begin
            bad++; $display("FAIL reset_b_sig_cnt got=%h/%h want=00/00", b_sig, b_pcnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small_pass();
        logic [7:0] sig_tab [5];
        logic       en_tab  [5];
        logic [7:0] exp_sig;
        logic       exp_en;
        sig_tab = '{8'h01, 8'h03, 8'h03, 8'h06, 8'h0D};
        en_tab  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        a_golden   = 8'h0D;
        a_scan_out = 1'b1;
        a_start    = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        total++;
        if (a_busy !== 1'b1 || a_scan_en !== 1'b1 || a_sig !== 8'h00) begin
            bad++; $display("FAIL small_start got busy=%b scan_en=%b sig=%h want 1 1 00", a_busy, a_scan_en, a_sig);
        end
        for (int i = 0; i < 5; i++) begin
            q_sig.push_back(sig_tab[i]);
            q_en.push_back(en_tab[i]);
            exp_en = q_en.pop_front();
            total++;
            if (a_scan_en !== exp_en) begin
                bad++; $display("FAIL small_scan_en step=%0d got=%b want=%b", i, a_scan_en, exp_en);
            end
            a_step = 1'b1;
            @(negedge clk);
            a_step = 1'b0;
            exp_sig = q_sig.pop_front();
            total++;
            if (a_sig !== exp_sig) begin
                bad++; $display("FAIL small_sig step=%0d got=%h want=%h", i, a_sig, exp_sig);
            end
        end
        total++;
        if (a_done !== 1'b0 || a_busy !== 1'b1) begin
            bad++; $display("FAIL small_check_state got done=%b busy=%b want 0 1", a_done, a_busy);
        end
        @(negedge clk);
        total++;
        if (a_done !== 1'b1 || a_pass !== 1'b1 || a_busy !== 1'b0 || a_pcnt !== 8'd1) begin
            bad++; $display("FAIL small_pass got done=%b pass=%b busy=%b pcnt=%0d want 1 1 0 1",
                            a_done, a_pass, a_busy, a_pcnt);
        end
    endtask

    task automatic test_small_fail();
        int k;
        a_golden   = 8'h0C;
        a_scan_out = 1'b1;
        a_start    = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        total++;
        if (a_done !== 1'b0 || a_pass !== 1'b0 || a_sig !== 8'h00 || a_busy !== 1'b1) begin
            bad++; $display("FAIL restart_from_done got done=%b pass=%b sig=%h busy=%b want 0 0 00 1",
                            a_done, a_pass, a_sig, a_busy);
        end
        repeat (5) begin
            a_step = 1'b1;
            @(negedge clk);
            a_step = 1'b0;
        end
        k = 0;
        while (a_done !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (a_done !== 1'b1 || a_pass !== 1'b0 || a_sig !== 8'h0D) begin
            bad++; $display("FAIL small_fail got done=%b pass=%b sig=%h want 1 0 0D", a_done, a_pass, a_sig);
        end
    endtask

    task automatic test_start_step_same();
        a_scan_out = 1'b1;
        a_start    = 1'b1;
        a_step     = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_step  = 1'b0;
        total++;
        if (a_sig !== 8'h00 || dut_a.r_shift_cnt !== '0 || a_scan_en !== 1'b1) begin
            bad++; $display("FAIL start_step_same got sig=%h shift_cnt=%0d scan_en=%b want 00 0 1",
                            a_sig, dut_a.r_shift_cnt, a_scan_en);
        end
        repeat (2) begin
            a_step = 1'b1;
            @(negedge clk);
            a_step = 1'b0;
        end
        total++;
        if (a_sig !== 8'h03 || a_scan_en !== 1'b0) begin
            bad++; $display("FAIL start_step_followup got sig=%h scan_en=%b want 03 0", a_sig, a_scan_en);
        end
    endtask

    task automatic test_start_busy();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        total++;
        if (a_sig !== 8'h03 || a_busy !== 1'b1 || a_pcnt !== 8'd0 || a_scan_en !== 1'b0) begin
            bad++; $display("FAIL start_while_busy got sig=%h busy=%b pcnt=%0d scan_en=%b want 03 1 0 0",
                            a_sig, a_busy, a_pcnt, a_scan_en);
        end
        a_step = 1'b1;
        @(negedge clk);
        a_step = 1'b1;
        @(negedge clk);
        a_step = 1'b0;
        total++;
        if (a_sig !== 8'h06 || a_pcnt !== 8'd1 || a_scan_en !== 1'b1) begin
            bad++; $display("FAIL into_unload got sig=%h pcnt=%0d scan_en=%b want 06 1 1", a_sig, a_pcnt, a_scan_en);
        end
    endtask

    task automatic test_rst_mid_unload();
        rst = 1'b1;
        #1;
        total++;
        if ({a_scan_en, a_busy, a_done, a_pass} !== 4'b0000 || a_sig !== 8'h00 || a_pcnt !== 8'd0) begin
            bad++; $display("FAIL rst_mid_unload got flags=%b sig=%h pcnt=%0d want 0000 00 0",
                            {a_scan_en, a_busy, a_done, a_pass}, a_sig, a_pcnt);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            a_step = 1'b1;
            @(negedge clk);
            a_step = 1'b0;
        end
        total++;
        if (a_done !== 1'b0 || a_busy !== 1'b0 || a_sig !== 8'h00) begin
            bad++; $display("FAIL rst_no_partial got done=%b busy=%b sig=%h want 0 0 00", a_done, a_busy, a_sig);
        end
    endtask

    task automatic test_scan_en_sweep();
        int   k;
        int   n;
        logic exp_en;
        b_golden   = 8'h00;
        b_scan_out = 1'b0;
        b_start    = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int p = 0; p < 16; p++) begin
            for (int s = 0; s < 8; s++) q_en.push_back(1'b1);
            q_en.push_back(1'b0);
        end
        for (int s = 0; s < 8; s++) q_en.push_back(1'b1);
        n = 0;
        while (q_en.size() > 0) begin
            exp_en = q_en.pop_front();
            total++;
            if (b_scan_en !== exp_en || b_done !== 1'b0) begin
                bad++; $display("FAIL sweep_scan_en step=%0d got scan_en=%b done=%b want %b 0",
                                n, b_scan_en, b_done, exp_en);
            end
            b_step = 1'b1;
            @(negedge clk);
            b_step = 1'b0;
            n++;
        end
        total++;
        if (b_done !== 1'b0 || b_scan_en !== 1'b0) begin
            bad++; $display("FAIL sweep_after_last got done=%b scan_en=%b want 0 0", b_done, b_scan_en);
        end
        k = 0;
        while (b_done !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (b_done !== 1'b1 || b_pass !== 1'b1 || b_pcnt !== 8'd16 || b_sig !== 8'h00) begin
            bad++; $display("FAIL sweep_done got done=%b pass=%b pcnt=%0d sig=%h want 1 1 16 00",
                            b_done, b_pass, b_pcnt, b_sig);
        end
        b_scan_out = 1'b1;
        repeat (3) begin
            b_step = 1'b1;
            @(negedge clk);
            b_step = 1'b0;
        end
        total++;
        if (b_pcnt !== 8'd16 || b_sig !== 8'h00 || b_done !== 1'b1) begin
            bad++; $display("FAIL step_in_done got pcnt=%0d sig=%h done=%b want 16 00 1", b_pcnt, b_sig, b_done);
        end
    endtask

    task automatic test_random_signature();
        logic       bits [152];
        logic [7:0] model;
        logic [7:0] exp_sig;
        int         k;
        model = 8'h00;
        for (int i = 0; i < 152; i++) begin
            bits[i] = 1'($urandom_range(0, 1));
            if (!(i < 144 && (i % 9) == 8)) model = sisr_model(model, bits[i]);
        end
        b_golden = model;
        b_start  = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        model = 8'h00;
        for (int i = 0; i < 152; i++) begin
            if (!(i < 144 && (i % 9) == 8)) model = sisr_model(model, bits[i]);
            q_sig.push_back(model);
            b_scan_out = bits[i];
            b_step     = 1'b1;
            @(negedge clk);
            b_step = 1'b0;
            exp_sig = q_sig.pop_front();
            if (b_sig !== exp_sig) begin
                total++; bad++;
                $display("FAIL random_sig step=%0d got=%h want=%h", i, b_sig, exp_sig);
            end
        end
        total++;
        if (b_sig !== model) begin
            bad++; $display("FAIL random_final_sig got=%h want=%h", b_sig, model);
        end
        k = 0;
        while (b_done !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (b_done !== 1'b1 || b_pass !== 1'b1) begin
            bad++; $display("FAIL random_pass got done=%b pass=%b want 1 1", b_done, b_pass);
        end
    endtask

    initial begin
        rst        = 1'b1;
        a_start    = 1'b0;
        a_step     = 1'b0;
        a_scan_out = 1'b0;
        a_golden   = 8'h00;
        b_start    = 1'b0;
        b_step     = 1'b0;
        b_scan_out = 1'b0;
        b_golden   = 8'h00;
        @(negedge clk);
        test_reset();
        test_small_pass();
        test_small_fail();
        test_start_step_same();
        test_start_busy();
        test_rst_mid_unload();
        test_scan_en_sweep();
        test_random_signature();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
